imem_shared_rom: RTL and testbench
==================================

# imem_shared_rom

Shared, loadable instruction memory for the single-cycle manycore. It replaces per-core hard-wired ROM copies with one array of `DEPTH` 32-bit words, serving `N_PORTS` core fetch ports through a round-robin arbiter with a one-cycle registered read. A boot-time load port writes program words. Fetches that are out of window or unaligned return a flagged default word.

## Interface
- `N_PORTS`, 4: number of core fetch ports (≥1).
- `DEPTH`, 32: words in the array; must be a power of two, 2..1024.
- `AW`, $clog2(DEPTH): word-index width (derived; do not override).
- `BASE_ADDRESS`, 0: required value of `addr[31:AW+2]` for a hit.
- `DEFAULT_WORD`, 32'h0000_ffff: data returned on error.
- `NOP_WORD`, 32'h0000_f020: reset contents of every word (`add $30,$0,$0`).

Ports:
- `clk`, in, 1: the single clock; all state updates on rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `req_valid`, in, N_PORTS: per-port fetch request.
- `req_addr`, in, 32*N_PORTS: byte address; port i occupies bits [32i+31:32i].
- `req_ready`, out, N_PORTS: one-hot (or zero) grant. Combinational from `req_valid`, `load_en` and the pointer.
- `rsp_valid`, out, N_PORTS: one-cycle pulse carrying the response for the port granted last cycle.
- `rsp_data`, out, 32*N_PORTS: instruction word; held until that port's next response.
- `rsp_err`, out, N_PORTS: set with `rsp_valid` when the request missed the window or was unaligned.
- `load_en`, in, 1: write strobe for the boot loader.
- `load_addr`, in, AW: word index to write.
- `load_data`, in, 32: word to write.

## Operation
- Arbitration:
  - Each cycle with `load_en`=0, grant the first port with `req_valid` set, searching upward (with wrap) from `rr_ptr`.
  - A transfer occurs when `req_valid[i] & req_ready[i]`.
  - On a transfer, `rr_ptr` ← i+1 mod N_PORTS. Otherwise `rr_ptr` is unchanged.
- Load priority:
  - While `load_en`=1, `req_ready`=0 for every port, and `mem[load_addr]` ← `load_data` at the edge.
  - Loads and fetches therefore never collide. A request arriving during a load waits; the requester keeps `req_valid` and `req_addr` stable.
- Decode:
  - hit = (`addr[31:AW+2]` == BASE_ADDRESS) && (`addr[1:0]` == 0).
  - On a hit, `rsp_data` = `mem[addr[AW+1:2]]`, `rsp_err`=0.
  - On a miss, `rsp_data` = DEFAULT_WORD, `rsp_err`=1.
- Responses have no backpressure; cores must accept the `rsp_valid` pulse.
- Read-after-load: a fetch granted in the cycle after a load to the same word returns the new data.
- Simulation only: a `$display` of time, port and address on every error response.

## Timing
- Reset values: `rr_ptr`=0, all `rsp_valid`=0, all `rsp_err`=0, all `rsp_data`=0, every `mem` word = NOP_WORD.
- Latency: a request granted in cycle n gives `rsp_valid` at n+1. Throughput is one fetch per cycle across all ports.
- Worst-case wait for a continuously requesting port is N_PORTS−1 cycles, excluding load cycles.
- `reset` asserted mid-operation clears everything immediately, including any in-flight response (no pulse) and any loaded program.
- N_PORTS=1: the pointer is constant 0, and `req_ready` = ~`load_en`.

## Structure
- Package `imem_pkg`: NOP_WORD, DEFAULT_WORD, and the `word_t` (32-bit) typedef, shared with the core's fetch stage.
- One sub-module, `rr_arbiter`:
  - Parameter N.
  - Inputs `req`, `enable`, `ptr`.
  - Outputs one-hot `gnt` and `gnt_idx`.
  - The pointer register lives in the parent.
- The memory array, decode and response registers stay in `imem_shared_rom`.

## Test plan
- Reset, then ports 0 and 2 fetch `0x00000000` every cycle:
  - Grants alternate 0, 2, 0, 2.
  - Each `rsp_valid` one cycle later with data 0x0000f020 and `rsp_err`=0.
- Load word 5 with 0x8c010000, then port 1 fetches `0x14` in the next cycle → `rsp_data`=0x8c010000 one cycle after the grant.
- All four ports request while `load_en` is high for 3 cycles:
  - No `req_ready` during those cycles.
  - Afterwards, grants follow in order from `rr_ptr` with no port starved.
- Port 3 fetches `0x00000006`, then `0x00000080` (DEPTH=32) → both give `rsp_err`=1 with `rsp_data`=0x0000ffff.
- Assert `reset` in the cycle a grant occurs:
  - No `rsp_valid` follows.
  - Memory reads back 0x0000f020.
  - First post-reset grant goes to the lowest requesting port.

Source files
------------

// File: rtl/imem_pkg.sv
// Types and constant words shared by the instruction memory and the core fetch stage.
package imem_pkg;

   typedef logic [31:0] word_t;

   // add $30,$0,$0 : harmless filler for every word not yet loaded
   localparam word_t NOP_WORD     = 32'h0000_f020;
   // returned (with an error flag) for out-of-window or unaligned fetches
   localparam word_t DEFAULT_WORD = 32'h0000_ffff;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or above ptr (with wrap).
// The pointer register is owned by the parent so it can advance only on a transfer.
module rr_arbiter #(
   parameter int N  = 4,
   parameter int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic          enable,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [PW-1:0] gnt_idx
);

   int idx;

   // Scan offsets from the far end down so the nearest requester to ptr is assigned last.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      idx     = 0;
      if (enable) begin
         for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % N;
            if (req[idx]) begin
               gnt      = '0;
               gnt[idx] = 1'b1;
               gnt_idx  = PW'(idx);
            end
         end
      end
   end

endmodule

// File: rtl/imem_shared_rom.sv
// Shared loadable instruction memory: N_PORTS fetch ports, round-robin arbitration,
// one-cycle registered read, boot-time load port with priority over fetches.
module imem_shared_rom
   import imem_pkg::*;
#(
   parameter int          N_PORTS      = 4,
   parameter int          DEPTH        = 32,
   parameter int          AW           = $clog2(DEPTH),
   parameter logic [31:0] BASE_ADDRESS = 32'h0,
   parameter word_t       DEFAULT_WORD = imem_pkg::DEFAULT_WORD,
   parameter word_t       NOP_WORD     = imem_pkg::NOP_WORD
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [N_PORTS-1:0]    req_valid,
   input  logic [32*N_PORTS-1:0] req_addr,
   output logic [N_PORTS-1:0]    req_ready,
   output logic [N_PORTS-1:0]    rsp_valid,
   output logic [32*N_PORTS-1:0] rsp_data,
   output logic [N_PORTS-1:0]    rsp_err,
   input  logic                  load_en,
   input  logic [AW-1:0]         load_addr,
   input  word_t                 load_data
);

   localparam int PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

   word_t               mem [DEPTH];
   logic [PW-1:0]       rr_ptr;
   logic [N_PORTS-1:0]  gnt;
   logic [PW-1:0]       gnt_idx;
   logic [31:0]         sel_addr;
   logic                hit;
   word_t               rd_word;

   // A load owns the cycle: the arbiter is disabled so fetches and loads never collide.
   rr_arbiter #(.N(N_PORTS), .PW(PW)) u_arb (
      .req     (req_valid),
      .enable  (~load_en),
      .ptr     (rr_ptr),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   assign req_ready = gnt;

   // Route the granted port's address to the decoder.
   always_comb begin
      sel_addr = '0;
      for (int i = 0; i < N_PORTS; i++) begin
         if (gnt[i]) sel_addr = req_addr[32*i +: 32];
      end
   end

   assign hit     = (sel_addr[31:AW+2] == BASE_ADDRESS[29-AW:0]) && (sel_addr[1:0] == 2'b00);
   assign rd_word = hit ? mem[sel_addr[AW+1:2]] : DEFAULT_WORD;

   // Pointer moves past the winner only when a transfer happened.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_ptr <= '0;
      end else if (|gnt) begin
         if (int'(gnt_idx) == N_PORTS - 1) rr_ptr <= '0;
         else                              rr_ptr <= gnt_idx + 1'b1;
      end
   end

   // Memory array: reset restores the NOP image, load port writes one word per cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= NOP_WORD;
      end else if (load_en) begin
         mem[load_addr] <= load_data;
      end
   end

   // Response registers: valid pulses for one cycle, data and error held per port.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rsp_valid <= '0;
         rsp_err   <= '0;
         rsp_data  <= '0;
      end else begin
         rsp_valid <= gnt;
         for (int i = 0; i < N_PORTS; i++) begin
            if (gnt[i]) begin
               rsp_data[32*i +: 32] <= rd_word;
               rsp_err[i]           <= ~hit;
            end
         end
      end
   end

`ifndef SYNTHESIS
   // Trace every fetch that will come back flagged, to help debug stray PCs.
   always_ff @(posedge clk) begin
      if (!reset && (|gnt) && !hit)
         $display("%0t imem_shared_rom: error response port %0d addr %h", $time, gnt_idx, sel_addr);
   end
`endif

endmodule

// File: tb/tb_imem_shared_rom.sv
// Bench for imem_shared_rom: directed scenarios plus random traffic, checked
// against a behavioural model of the memory, arbitration rule and decode.
module tb_imem_shared_rom;
   import imem_pkg::*;

   localparam int NP    = 4;
   localparam int DEPTH = 32;
   localparam int AW    = 5;

   logic             clk = 1'b0;
   logic             reset;
   logic [NP-1:0]    req_valid;
   logic [32*NP-1:0] req_addr;
   logic [NP-1:0]    req_ready;
   logic [NP-1:0]    rsp_valid;
   logic [32*NP-1:0] rsp_data;
   logic [NP-1:0]    rsp_err;
   logic             load_en;
   logic [AW-1:0]    load_addr;
   word_t            load_data;

   imem_shared_rom #(.N_PORTS(NP), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_addr  (req_addr),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .rsp_err   (rsp_err),
      .load_en   (load_en),
      .load_addr (load_addr),
      .load_data (load_data)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
   endtask

   // ---------------- reference model ----------------
   word_t         m_mem  [DEPTH];
   int            m_ptr;
   logic [NP-1:0] m_exp_valid;
   word_t         m_data [NP];
   logic          m_err  [NP];
   logic [31:0]   addr_q [NP];

   function automatic void model_reset();
      for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0000_f020;
      m_ptr       = 0;
      m_exp_valid = '0;
      for (int p = 0; p < NP; p++) begin
         m_data[p] = 32'h0;
         m_err[p]  = 1'b0;
      end
   endfunction

   function automatic int model_grant(input logic [NP-1:0] v, input logic le);
      if (le) return -1;
      for (int k = 0; k < NP; k++) begin
         if (v[(m_ptr + k) % NP]) return (m_ptr + k) % NP;
      end
      return -1;
   endfunction

   // One clock: drive, check combinational grant and last cycle's response, advance model.
   task automatic cycle(input logic [NP-1:0] v, input logic le,
                        input logic [AW-1:0] la, input word_t ld);
      int g;
      logic [31:0] a;
      logic [NP-1:0] exp_rdy;
      req_valid = v;
      load_en   = le;
      load_addr = la;
      load_data = ld;
      for (int p = 0; p < NP; p++) req_addr[32*p +: 32] = addr_q[p];
      @(negedge clk);
      g       = model_grant(v, le);
      exp_rdy = (g < 0) ? '0 : NP'(1 << g);
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      chk("rsp_valid", 32'(rsp_valid), 32'(m_exp_valid));
      for (int p = 0; p < NP; p++) begin
         chk($sformatf("rsp_data[%0d]", p), rsp_data[32*p +: 32], m_data[p]);
         if (m_exp_valid[p]) chk($sformatf("rsp_err[%0d]", p), 32'(rsp_err[p]), 32'(m_err[p]));
      end
      m_exp_valid = '0;
      if (le) m_mem[int'(la)] = ld;
      if (g >= 0) begin
         a = addr_q[g];
         m_exp_valid[g] = 1'b1;
         if ((a >> (AW + 2)) == 0 && a % 4 == 0) begin
            m_data[g] = m_mem[(a / 4) % DEPTH];
            m_err[g]  = 1'b0;
         end else begin
            m_data[g] = 32'h0000_ffff;
            m_err[g]  = 1'b1;
         end
         m_ptr = (g + 1) % NP;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      cycle('0, 1'b0, '0, '0);
   endtask

   initial begin
      logic [NP-1:0] v;
      logic          le;
      int            r;
      reset     = 1'b1;
      req_valid = '0;
      req_addr  = '0;
      load_en   = 1'b0;
      load_addr = '0;
      load_data = '0;
      for (int p = 0; p < NP; p++) addr_q[p] = 32'h0;
      model_reset();
      #12;
      chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("reset_rsp_err", 32'(rsp_err), 32'h0);
      chk("reset_rsp_data_lo", rsp_data[63:0] == 64'h0 ? 32'h0 : 32'h1, 32'h0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // ports 0 and 2 fetch address 0 continuously: grants alternate 0,2,...
      for (int c = 0; c < 6; c++) cycle(4'b0101, 1'b0, '0, '0);
      idle();

      // load word 5, then port 1 fetches 0x14 on the next cycle
      cycle('0, 1'b1, 5'd5, 32'h8c01_0000);
      addr_q[1] = 32'h14;
      cycle(4'b0010, 1'b0, '0, '0);
      idle();

      // all ports request through a 3-cycle load, then drain in round-robin order
      for (int p = 0; p < NP; p++) addr_q[p] = 32'(p * 4);
      for (int c = 0; c < 3; c++) cycle(4'b1111, 1'b1, AW'(10 + c), 32'hA000_0000 + 32'(c));
      for (int c = 0; c < 8; c++) cycle(4'b1111, 1'b0, '0, '0);
      idle();

      // port 3: unaligned, then just outside the window
      addr_q[3] = 32'h0000_0006;
      cycle(4'b1000, 1'b0, '0, '0);
      addr_q[3] = 32'h0000_0080;
      cycle(4'b1000, 1'b0, '0, '0);
      idle();

      // reset asserted in the middle of a grant cycle
      cycle('0, 1'b1, 5'd5, 32'h8c01_0000);
      for (int p = 0; p < NP; p++) addr_q[p] = 32'h0;
      cycle(4'b0100, 1'b0, '0, '0);
      req_valid = 4'b0001;
      @(negedge clk);
      chk("rst_cycle_ready", 32'(req_ready), 32'h1);
      reset = 1'b1;
      #1;
      chk("rst_async_valid", 32'(rsp_valid), 32'h0);
      chk("rst_async_data2", rsp_data[95:64], 32'h0);
      model_reset();
      @(posedge clk);
      #1;
      chk("rst_no_pulse", 32'(rsp_valid), 32'h0);
      reset = 1'b0;
      addr_q[1] = 32'h14;
      addr_q[3] = 32'h14;
      cycle(4'b1010, 1'b0, '0, '0);
      idle();

      // random traffic
      for (int c = 0; c < 400; c++) begin
         for (int p = 0; p < NP; p++) begin
            r = int'($urandom_range(0, 9));
            if (r < 7)       addr_q[p] = 32'($urandom_range(0, DEPTH - 1)) << 2;
            else if (r == 7) addr_q[p] = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
            else if (r == 8) addr_q[p] = 32'h80 << $urandom_range(0, 24);
            else             addr_q[p] = $urandom;
         end
         v  = NP'($urandom);
         le = ($urandom_range(0, 7) == 0);
         cycle(v, le, AW'($urandom), $urandom);
      end
      idle();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
